memwb_pipe_stage: RTL
=====================

Name: memwb_pipe_stage

Overview:
- Parametrised MEM/WB pipeline stage between data-memory access and register-file writeback.
- Carries the mem-to-reg select (MReg), register-write enable (EnRW), load data, ALU result and destination register.
- Adds valid/ready handshake, a 2-entry skid buffer for full throughput under back-pressure, flush, and bubble write-suppression.
- Sits between the MEM stage and the register-file write port.

Parameters:
- DATA_W, 32, width of read_data and ALU_out.
- RD_W, 4, width of destination register index.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  MEM stage presents a valid instruction.
- in_ready  out  1  stage can accept; registered (= skid slot empty).
- MReg_in  in  1  1 = write back read_data, 0 = write back ALU_out.
- EnRW_in  in  1  register write enable.
- read_data_in  in  DATA_W  data-memory load result.
- ALU_out_in  in  DATA_W  ALU result.
- reg_rd_in  in  RD_W  destination register.
- flush  in  1  kill all held and incoming instructions.
- out_valid  out  1  WB payload valid.
- out_ready  in  1  WB consumer accepts this cycle.
- MReg_out  out  1  held select.
- EnRW_out  out  1  held write enable, gated: EnRW_main & out_valid.
- read_data_out  out  DATA_W  held load data.
- ALU_out_out  out  DATA_W  held ALU result.
- reg_rd_out  out  RD_W  held destination.

Behaviour:
- Storage:
  - main slot: drives outputs.
  - skid slot: catches one beat accepted while main is stalled.
- Reset (async, rst=1): both valid bits 0, all payload regs 0. Result: out_valid=0, in_ready=1, every output 0.
- Accept: in_fire = in_valid & in_ready. Drain: out_fire = out_valid & out_ready.
- Main load enable: out_fire | !out_valid.
  - When enabled, main loads skid if skid valid, else input if in_fire, else main valid goes 0.
- Skid capture: in_fire & out_valid & !out_ready → skid captures input; in_ready drops next cycle.
- Skid release: skid clears when it moves to main.
- Simultaneous in_fire and out_fire with skid empty: input goes straight to main.
- Latency: 1 cycle in_fire → out_valid when unstalled. Throughput: 1 beat/cycle.
- Ordering: strict FIFO; skid content always precedes input.
- Full (both slots valid): in_ready=0; input ignored regardless of in_valid.
- Flush:
  - Next edge clears both valid bits.
  - Same-cycle input dropped even if in_fire.
  - Payload regs may hold stale data; EnRW_out=0 while out_valid=0.
  - Flush dominates out_ready and in_valid.
- Reset mid-operation: immediate clear; no partial writeback; EnRW_out falls asynchronously.
- No width arithmetic; payload copied bit-exact.

Optional Feature:
- Macro: MEMWB_FWD_EN.
- Defined, adds three outputs:
  - fwd_valid (1) = out_valid & EnRW_main.
  - fwd_rd (RD_W) = reg_rd_out.
  - fwd_data (DATA_W) = MReg_out ? read_data_out : ALU_out_out.
  - All combinational from the main slot, for EX-stage hazard forwarding.
- Not defined: ports and mux absent; core behaviour identical.

Decomposition:
- Package memwb_pkg:
  - PAYLOAD_W = 2 + 2*DATA_W + RD_W.
  - Field offset localparams for MReg, EnRW, read_data, ALU_out, reg_rd.
  - Payload pack/unpack function.
- Sub-module pipe_slot: one valid bit plus PAYLOAD_W register with load/clear/async reset, instantiated twice (main, skid).

Test Plan:
- Reset: assert rst mid-run with both slots full → out_valid=0, EnRW_out=0, in_ready=1 immediately; all outputs 0.
- Streaming: out_ready=1, 4 back-to-back beats with ALU_out_in=0x11..0x44, reg_rd_in=1..4 → appear 1 cycle later in order, one per cycle, in_ready stays 1.
- Back-pressure: out_ready=0 while sending 0xA0, 0xA1, 0xA2:
  - main=0xA0, skid=0xA1, in_ready=0; 0xA2 held by source.
  - Release out_ready → outputs 0xA0, 0xA1, 0xA2 on consecutive cycles, no loss or duplication.
- Flush: both slots full plus in_valid with 0xBB, pulse flush → next cycle out_valid=0, EnRW_out=0, in_ready=1; 0xBB never appears.
- Bubble gating: in_valid=0 with EnRW_in=1 → EnRW_out stays 0.
- MEMWB_FWD_EN: MReg_in=1, read_data_in=0xDEAD, ALU_out_in=0x1234, EnRW_in=1, reg_rd_in=7 → fwd_valid=1, fwd_rd=7, fwd_data=0xDEAD; with MReg_in=0 → fwd_data=0x1234.

Source files
------------

// File: rtl/memwb_pkg.sv
// rtl/memwb_pkg.sv - MEM/WB payload layout helpers shared by the stage and its slots
// Payload is packed {MReg, EnRW, read_data, ALU_out, reg_rd}, reg_rd at bit 0.
package memwb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int RD_W_DEF   = 4;

  function automatic int payload_w(input int data_w, input int rd_w);
    return 2 + 2 * data_w + rd_w;
  endfunction

  function automatic int off_reg_rd();
    return 0;
  endfunction

  function automatic int off_alu(input int rd_w);
    return rd_w;
  endfunction

  function automatic int off_rdata(input int data_w, input int rd_w);
    return rd_w + data_w;
  endfunction

  function automatic int off_enrw(input int data_w, input int rd_w);
    return rd_w + 2 * data_w;
  endfunction

  function automatic int off_mreg(input int data_w, input int rd_w);
    return rd_w + 2 * data_w + 1;
  endfunction

endpackage

// File: rtl/memwb_pipe_stage_slot.sv
// rtl/memwb_pipe_stage_slot.sv - one valid bit plus payload register (pipe_slot)
// Clear drops only the valid bit; payload is left stale on purpose.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = valid_i;
      if (valid_i) data_d = data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/memwb_pipe_stage.sv
// rtl/memwb_pipe_stage.sv - MEM/WB stage with valid/ready skid buffer and flush
// Optional MEMWB_FWD_EN adds combinational forwarding outputs from the main slot.
module memwb_pipe_stage
  import memwb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_W   = RD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              MReg_in,
  input  logic              EnRW_in,
  input  logic [DATA_W-1:0] read_data_in,
  input  logic [DATA_W-1:0] ALU_out_in,
  input  logic [RD_W-1:0]   reg_rd_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef MEMWB_FWD_EN
  output logic              fwd_valid,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic              MReg_out,
  output logic              EnRW_out,
  output logic [DATA_W-1:0] read_data_out,
  output logic [DATA_W-1:0] ALU_out_out,
  output logic [RD_W-1:0]   reg_rd_out
);

  localparam int PW      = payload_w(DATA_W, RD_W);
  localparam int O_RD    = off_reg_rd();
  localparam int O_ALU   = off_alu(RD_W);
  localparam int O_RDATA = off_rdata(DATA_W, RD_W);
  localparam int O_ENRW  = off_enrw(DATA_W, RD_W);
  localparam int O_MREG  = off_mreg(DATA_W, RD_W);

  logic [PW-1:0] in_payload, main_data, skid_data;
  logic          main_valid, skid_valid;
  logic          in_fire, out_fire, main_en, skid_capture, skid_release;

  assign in_payload = {MReg_in, EnRW_in, read_data_in, ALU_out_in, reg_rd_in};

  // in_ready comes straight from the skid valid flop, so it is registered.
  assign in_ready     = !skid_valid;
  assign in_fire      = in_valid & in_ready;
  assign out_fire     = main_valid & out_ready;
  assign main_en      = out_fire | !main_valid;
  assign skid_capture = in_fire & main_valid & !out_ready;
  assign skid_release = skid_valid & main_en;

  pipe_slot #(.W(PW)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (main_en),
    .clear_i (flush),
    .valid_i (skid_valid | in_fire),
    .data_i  (skid_valid ? skid_data : in_payload),
    .valid_o (main_valid),
    .data_o  (main_data)
  );

  pipe_slot #(.W(PW)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_capture | skid_release),
    .clear_i (flush),
    .valid_i (skid_capture),
    .data_i  (in_payload),
    .valid_o (skid_valid),
    .data_o  (skid_data)
  );

  assign out_valid     = main_valid;
  assign MReg_out      = main_data[O_MREG];
  assign EnRW_out      = main_data[O_ENRW] & main_valid;
  assign read_data_out = main_data[O_RDATA +: DATA_W];
  assign ALU_out_out   = main_data[O_ALU +: DATA_W];
  assign reg_rd_out    = main_data[O_RD +: RD_W];

`ifdef MEMWB_FWD_EN
  assign fwd_valid = main_valid & main_data[O_ENRW];
  assign fwd_rd    = reg_rd_out;
  assign fwd_data  = MReg_out ? read_data_out : ALU_out_out;
`endif

endmodule
